adder_scheduler: RTL and testbench

Sequencer and arbiter for the shared four-operand adder datapath. Accepts add requests from `NREQ` requesters, selects one per operation, drives the datapath's operand source select, register loads, accumulation mux selects and output enable through a fixed six-state sequence, and signals completion to the granted requester. Sits between the requester blocks and the adder datapath, replacing per-requester ad-hoc sequencing.

---
 rtl/adder_scheduler_if.sv | 45 ++++
 rtl/adder_scheduler.sv | 196 +++++++++++++++++++
 tb/tb_adder_scheduler.sv | 219 +++++++++++++++++++++
 3 files changed

// File: rtl/adder_scheduler_if.sv
// -----------------------------------------------------------------------------
// adder_scheduler_if
// Bundles the requester handshake and the adder datapath control strobes that
// the scheduler drives.
//   master : scheduler side (drives grant/src_sel/controls, reads req)
//   slave  : requester/datapath side (drives req, reads everything else)
// Signals:
//   req[NREQ]      per-requester level request
//   grant[NREQ]    one-hot datapath owner, 0 when idle
//   src_sel[SELW]  index of the granted requester (operand mux steer)
//   aload..dload   datapath register load strobes
//   asel, bsel[2]  adder input selects
//   output_enable  datapath result valid
//   done           one-cycle completion pulse
//   busy           scheduler not idle
// -----------------------------------------------------------------------------
interface adder_scheduler_if #(
    parameter int unsigned NREQ = 4,
    parameter int unsigned SELW = 2
);
    logic [NREQ-1:0] req;
    logic [NREQ-1:0] grant;
    logic [SELW-1:0] src_sel;
    logic            aload;
    logic            bload;
    logic            cload;
    logic            dload;
    logic            asel;
    logic [1:0]      bsel;
    logic            output_enable;
    logic            done;
    logic            busy;

    modport master (
        input  req,
        output grant, src_sel, aload, bload, cload, dload,
        output asel, bsel, output_enable, done, busy
    );

    modport slave (
        output req,
        input  grant, src_sel, aload, bload, cload, dload,
        input  asel, bsel, output_enable, done, busy
    );
endinterface

// File: rtl/adder_scheduler.sv
// -----------------------------------------------------------------------------
// adder_scheduler
// Arbitrates NREQ requesters onto the shared four-operand adder and steps the
// datapath through GRANT -> LOAD -> ADD1 -> ADD2 -> ADD3 -> FIN. All outputs
// are registered and updated together with the state, so they are a pure
// function of the current state and latched grant.
// Ports:
//   i_clk       clock, rising edge
//   i_rst_n     asynchronous active-low reset
//   bus         adder_scheduler_if.master (req in; grant/src_sel/controls out)
//   o_op_count  completed-operation counter, wraps 255 -> 0
// Build option:
//   ADDER_SCHED_RR_EN  defined   : round-robin arbitration with pointer
//                      undefined : fixed priority, lowest index wins
// -----------------------------------------------------------------------------
module adder_scheduler #(
    parameter int unsigned NREQ = 4,
    parameter int unsigned SELW = 2
) (
    input  logic                i_clk,
    input  logic                i_rst_n,
    adder_scheduler_if.master   bus,
    output logic [7:0]          o_op_count
);

    typedef enum logic [2:0] {
        StIdle,
        StGrant,
        StLoad,
        StAdd1,
        StAdd2,
        StAdd3,
        StFin
    } state_e;

    state_e          r_state;
    logic [NREQ-1:0] r_grant;
    logic [SELW-1:0] r_src_sel;
    logic            r_loads;
    logic            r_asel;
    logic [1:0]      r_bsel;
    logic            r_oe;
    logic            r_done;
    logic            r_busy;
    logic [7:0]      r_op_count;

    logic            w_any;
    logic [SELW-1:0] w_win_idx;
    logic [NREQ-1:0] w_win_onehot;

`ifdef ADDER_SCHED_RR_EN
    logic [SELW-1:0] r_rr_ptr;
    logic [SELW-1:0] w_ptr_next;
    logic [SELW:0]   w_sum;
    logic [SELW-1:0] w_cand;
    logic            w_found;

    // Search starts at the pointer and wraps modulo NREQ; first hit wins.
    always_comb begin
        w_found   = 1'b0;
        w_win_idx = '0;
        w_sum     = '0;
        w_cand    = '0;
        for (int unsigned k = 0; k < NREQ; k++) begin
            w_sum = {1'b0, r_rr_ptr} + (SELW+1)'(k);
            if (w_sum >= (SELW+1)'(NREQ)) begin
                w_sum = w_sum - (SELW+1)'(NREQ);
            end
            w_cand = w_sum[SELW-1:0];
            if (!w_found && bus.req[w_cand]) begin
                w_found   = 1'b1;
                w_win_idx = w_cand;
            end
        end
    end

    assign w_ptr_next = (w_win_idx == SELW'(NREQ - 1)) ? '0 : w_win_idx + SELW'(1);
`else
    // Scan from the top so the lowest set index is the last write and wins.
    always_comb begin
        w_win_idx = '0;
        for (int k = NREQ - 1; k >= 0; k--) begin
            if (bus.req[SELW'(k)]) begin
                w_win_idx = SELW'(k);
            end
        end
    end
`endif

    assign w_any        = |bus.req;
    assign w_win_onehot = NREQ'(1) << w_win_idx;

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state    <= StIdle;
            r_grant    <= '0;
            r_src_sel  <= '0;
            r_loads    <= 1'b0;
            r_asel     <= 1'b0;
            r_bsel     <= 2'b00;
            r_oe       <= 1'b0;
            r_done     <= 1'b0;
            r_busy     <= 1'b0;
            r_op_count <= 8'd0;
`ifdef ADDER_SCHED_RR_EN
            r_rr_ptr   <= '0;
`endif
        end else begin
            unique case (r_state)
                StIdle: begin
                    if (w_any) begin
                        r_state   <= StGrant;
                        r_grant   <= w_win_onehot;
                        r_src_sel <= w_win_idx;
                        r_busy    <= 1'b1;
`ifdef ADDER_SCHED_RR_EN
                        r_rr_ptr  <= w_ptr_next;
`endif
                    end
                end
                // Operand mux settle cycle; next state asserts all loads.
                StGrant: begin
                    r_state <= StLoad;
                    r_loads <= 1'b1;
                end
                StLoad: begin
                    r_state <= StAdd1;
                    r_loads <= 1'b0;
                    r_asel  <= 1'b1;
                    r_bsel  <= 2'b00;
                end
                StAdd1: begin
                    r_state <= StAdd2;
                    r_asel  <= 1'b0;
                    r_bsel  <= 2'b01;
                end
                StAdd2: begin
                    r_state <= StAdd3;
                    r_asel  <= 1'b0;
                    r_bsel  <= 2'b10;
                end
                StAdd3: begin
                    r_state <= StFin;
                    r_bsel  <= 2'b00;
                    r_oe    <= 1'b1;
                    r_done  <= 1'b1;
                end
                StFin: begin
                    r_oe       <= 1'b0;
                    r_done     <= 1'b0;
                    r_op_count <= r_op_count + 8'd1;
                    // Pending requests chain straight into the next GRANT.
                    if (w_any) begin
                        r_state   <= StGrant;
                        r_grant   <= w_win_onehot;
                        r_src_sel <= w_win_idx;
                        r_busy    <= 1'b1;
`ifdef ADDER_SCHED_RR_EN
                        r_rr_ptr  <= w_ptr_next;
`endif
                    end else begin
                        r_state   <= StIdle;
                        r_grant   <= '0;
                        r_src_sel <= '0;
                        r_busy    <= 1'b0;
                    end
                end
                default: begin
                    r_state   <= StIdle;
                    r_grant   <= '0;
                    r_src_sel <= '0;
                    r_loads   <= 1'b0;
                    r_asel    <= 1'b0;
                    r_bsel    <= 2'b00;
                    r_oe      <= 1'b0;
                    r_done    <= 1'b0;
                    r_busy    <= 1'b0;
                end
            endcase
        end
    end

    assign bus.grant         = r_grant;
    assign bus.src_sel       = r_src_sel;
    assign bus.aload         = r_loads;
    assign bus.bload         = r_loads;
    assign bus.cload         = r_loads;
    assign bus.dload         = r_loads;
    assign bus.asel          = r_asel;
    assign bus.bsel          = r_bsel;
    assign bus.output_enable = r_oe;
    assign bus.done          = r_done;
    assign bus.busy          = r_busy;
    assign o_op_count        = r_op_count;

endmodule

// File: tb/tb_adder_scheduler.sv
module tb_adder_scheduler;
    localparam int unsigned NREQ = 4;
    localparam int unsigned SELW = 2;

    logic       clk = 1'b0;
    logic       rst_n;
    logic [7:0] op_count;

    adder_scheduler_if #(.NREQ(NREQ), .SELW(SELW)) bus ();

    adder_scheduler #(.NREQ(NREQ), .SELW(SELW)) dut (
        .i_clk      (clk),
        .i_rst_n    (rst_n),
        .bus        (bus),
        .o_op_count (op_count)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [3:0] grant;
        logic [1:0] src;
        logic [3:0] loads;   // {aload, bload, cload, dload}
        logic       asel;
        logic [1:0] bsel;
        logic       oe;
        logic       done;
        logic       busy;
    } outs_t;

    typedef struct packed {
        logic [3:0] req;
        outs_t      exp;
    } vec_t;

    int    errors = 0;
    int    checks = 0;
    vec_t  vecs [21];
    int    nvec = 0;
    outs_t idle_o;
    logic [3:0] rr_exp [5];
    logic [1:0] rr_src [5];
    logic [3:0] exp_b_g;
    logic [1:0] exp_b_s;

    function automatic outs_t mk(logic [3:0] g, logic [1:0] s, logic [3:0] ld, logic a,
                                 logic [1:0] b, logic oe, logic dn, logic by);
        outs_t o;
        o.grant = g; o.src = s; o.loads = ld; o.asel = a;
        o.bsel = b; o.oe = oe; o.done = dn; o.busy = by;
        return o;
    endfunction

    function automatic outs_t sample();
        outs_t o;
        o.grant = bus.grant;
        o.src   = bus.src_sel;
        o.loads = {bus.aload, bus.bload, bus.cload, bus.dload};
        o.asel  = bus.asel;
        o.bsel  = bus.bsel;
        o.oe    = bus.output_enable;
        o.done  = bus.done;
        o.busy  = bus.busy;
        return o;
    endfunction

    task automatic check_outs(string name, outs_t exp);
        outs_t got;
        got = sample();
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got grant=%b src=%0d loads=%b asel=%b bsel=%b oe=%b done=%b busy=%b; want grant=%b src=%0d loads=%b asel=%b bsel=%b oe=%b done=%b busy=%b",
                     name, got.grant, got.src, got.loads, got.asel, got.bsel, got.oe,
                     got.done, got.busy, exp.grant, exp.src, exp.loads, exp.asel,
                     exp.bsel, exp.oe, exp.done, exp.busy);
        end
    endtask

    task automatic check_cnt(string name, logic [7:0] exp);
        checks++;
        if (op_count !== exp) begin
            errors++;
            $display("FAIL %s: op_count=%0d want %0d", name, op_count, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Seven rows per operation: GRANT, LOAD, ADD1, ADD2, ADD3, FIN, then IDLE.
    // Rows from drop_at onward drive req low.
    task automatic add_op(logic [3:0] r, logic [3:0] g, logic [1:0] s, int drop_at);
        outs_t rows [7];
        rows[0] = mk(g, s, 4'h0, 1'b0, 2'b00, 1'b0, 1'b0, 1'b1);
        rows[1] = mk(g, s, 4'hF, 1'b0, 2'b00, 1'b0, 1'b0, 1'b1);
        rows[2] = mk(g, s, 4'h0, 1'b1, 2'b00, 1'b0, 1'b0, 1'b1);
        rows[3] = mk(g, s, 4'h0, 1'b0, 2'b01, 1'b0, 1'b0, 1'b1);
        rows[4] = mk(g, s, 4'h0, 1'b0, 2'b10, 1'b0, 1'b0, 1'b1);
        rows[5] = mk(g, s, 4'h0, 1'b0, 2'b00, 1'b1, 1'b1, 1'b1);
        rows[6] = idle_o;
        for (int i = 0; i < 7; i++) begin
            vecs[nvec].req = (i >= drop_at) ? 4'b0000 : r;
            vecs[nvec].exp = rows[i];
            nvec++;
        end
    endtask

    initial begin
        int n;
        int cyc;
        idle_o = mk(4'h0, 2'd0, 4'h0, 1'b0, 2'b00, 1'b0, 1'b0, 1'b0);
`ifdef ADDER_SCHED_RR_EN
        rr_exp[0] = 4'b0001; rr_exp[1] = 4'b0010; rr_exp[2] = 4'b0100;
        rr_exp[3] = 4'b1000; rr_exp[4] = 4'b0001;
        rr_src[0] = 2'd0; rr_src[1] = 2'd1; rr_src[2] = 2'd2;
        rr_src[3] = 2'd3; rr_src[4] = 2'd0;
        exp_b_g = 4'b1000;   // pointer sits at 3 after granting requester 2
        exp_b_s = 2'd3;
`else
        for (int i = 0; i < 5; i++) begin
            rr_exp[i] = 4'b0001;
            rr_src[i] = 2'd0;
        end
        exp_b_g = 4'b0010;
        exp_b_s = 2'd1;
`endif

        rst_n   = 1'b0;
        bus.req = 4'b0000;
        #2;
        check_outs("reset_async", idle_o);
        check_cnt("reset_count", 8'd0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        tick();
        check_outs("idle_no_req", idle_o);

        // Table-driven: single op, priority/round-robin op, drop during ADD1.
        add_op(4'b0100, 4'b0100, 2'd2, 6);
        add_op(4'b1010, exp_b_g, exp_b_s, 6);
        add_op(4'b0010, 4'b0010, 2'd1, 3);
        for (int i = 0; i < nvec; i++) begin
            bus.req = vecs[i].req;
            tick();
            check_outs($sformatf("vec%0d", i), vecs[i].exp);
            if (i == 6) check_cnt("count_after_first", 8'd1);
        end
        check_cnt("count_after_table", 8'd3);

        // Asynchronous reset in the middle of ADD2.
        bus.req = 4'b0001;
        repeat (4) tick();
        check_outs("pre_reset_add2", mk(4'b0001, 2'd0, 4'h0, 1'b0, 2'b01, 1'b0, 1'b0, 1'b1));
        #2 rst_n = 1'b0;
        #1;
        check_outs("reset_mid_add2", idle_o);
        check_cnt("reset_mid_count", 8'd0);
        #1 rst_n = 1'b1;
        tick();
        check_outs("grant_after_release",
                   mk(4'b0001, 2'd0, 4'h0, 1'b0, 2'b00, 1'b0, 1'b0, 1'b1));

        // Back-to-back with all requesters asserted, pointer freshly reset.
        #1 rst_n = 1'b0;
        bus.req = 4'b1111;
        #1 rst_n = 1'b1;
        for (int op = 0; op < 5; op++) begin
            tick();
            check_outs($sformatf("b2b_grant%0d", op),
                       mk(rr_exp[op], rr_src[op], 4'h0, 1'b0, 2'b00, 1'b0, 1'b0, 1'b1));
            repeat (5) tick();
            check_outs($sformatf("b2b_fin%0d", op),
                       mk(rr_exp[op], rr_src[op], 4'h0, 1'b0, 2'b00, 1'b1, 1'b1, 1'b1));
        end
        bus.req = 4'b0000;
        tick();
        check_outs("b2b_idle", idle_o);
        check_cnt("b2b_count", 8'd5);

        // Counter wrap over 256 operations.
        #1 rst_n = 1'b0;
        bus.req = 4'b0001;
        #1 rst_n = 1'b1;
        n   = 0;
        cyc = 0;
        while (n < 255 && cyc < 2000) begin
            tick();
            cyc++;
            if (bus.done === 1'b1) n++;
        end
        checks++;
        if (n != 255) begin
            errors++;
            $display("FAIL wrap_wait255: saw %0d done pulses want 255", n);
        end
        tick();
        check_cnt("count_255", 8'd255);
        while (n < 256 && cyc < 2000) begin
            tick();
            cyc++;
            if (bus.done === 1'b1) n++;
        end
        checks++;
        if (n != 256) begin
            errors++;
            $display("FAIL wrap_wait256: saw %0d done pulses want 256", n);
        end
        tick();
        check_cnt("count_wrap", 8'd0);
        bus.req = 4'b0000;

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
